// File: rtl/seq_div_pkg.sv
// Shared definitions for the sequential restoring divider.
package seq_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_div_step.sv
// One restoring-division step: compare the shifted partial remainder with the
// divisor, subtract when it fits, and report the resulting quotient bit.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    always_comb begin
        q_bit = (rem_in >= {1'b0, divisor});
        // Any difference is below the divisor, so WIDTH bits always hold it exactly.
        rem_out = q_bit ? (rem_in[WIDTH-1:0] - divisor) : rem_in[WIDTH-1:0];
    end

endmodule

// File: rtl/seq_div.sv
// Sequential unsigned divider: restoring algorithm, one quotient bit per clock,
// with a one-cycle done pulse and a divide-by-zero shortcut.
module seq_div
    import seq_div_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_b,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int unsigned      CNT_W     = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   dvd_q, dvd_d;
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   quo_q, quo_d;
    logic [WIDTH-1:0]   res_rem_q, res_rem_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   step_rem;
    logic               step_q;

    // rem_q holds the already-shifted partial remainder about to be compared;
    // dvd_q shifts out unused dividend bits at the top and collects quotient bits at the bottom.
    div_step #(.WIDTH(WIDTH)) u_step (
        .rem_in  (rem_q),
        .divisor (dvs_q),
        .rem_out (step_rem),
        .q_bit   (step_q)
    );

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        quo_d     = quo_q;
        res_rem_d = res_rem_q;
        dbz_d     = dbz_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d = BUSY;
                    rem_d   = {{WIDTH{1'b0}}, dividend[WIDTH-1]};
                    dvd_d   = {dividend[WIDTH-2:0], 1'b0};
                    dvs_d   = divisor;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (dvs_q == '0) begin
                    // First BUSY cycle: the untouched dividend is split across rem_q[0] and dvd_q.
                    quo_d     = '1;
                    res_rem_d = {rem_q[0], dvd_q[WIDTH-1:1]};
                    dbz_d     = 1'b1;
                    state_d   = DONE;
                end else begin
                    rem_d = {step_rem, dvd_q[WIDTH-1]};
                    dvd_d = {dvd_q[WIDTH-2:0], step_q};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_ITER) begin
                        quo_d     = {dvd_q[WIDTH-2:0], step_q};
                        res_rem_d = step_rem;
                        dbz_d     = 1'b0;
                        state_d   = DONE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q   <= IDLE;
            rem_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            cnt_q     <= '0;
            quo_q     <= '0;
            res_rem_q <= '0;
            dbz_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            cnt_q     <= cnt_d;
            quo_q     <= quo_d;
            res_rem_q <= res_rem_d;
            dbz_q     <= dbz_d;
        end
    end

    assign busy        = (state_q == BUSY);
    assign done        = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = res_rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div.sv
// Bench for seq_div: directed and random operations at WIDTH=8 against plain
// integer division, plus an exhaustive WIDTH=4 sweep.
module tb_seq_div;

    logic       clk = 1'b0;
    logic       rst_b;
    logic       start8, start4;
    logic [7:0] dvd8, dvs8, quo8, rem8;
    logic [3:0] dvd4, dvs4, quo4, rem4;
    logic       busy8, done8, dbz8;
    logic       busy4, done4, dbz4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_div #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_b(rst_b), .start(start8), .dividend(dvd8), .divisor(dvs8),
        .busy(busy8), .done(done8), .quotient(quo8), .remainder(rem8), .div_by_zero(dbz8)
    );

    seq_div #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_b(rst_b), .start(start4), .dividend(dvd4), .divisor(dvs4),
        .busy(busy4), .done(done4), .quotient(quo4), .remainder(rem4), .div_by_zero(dbz4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called #1 after the accepting edge; counts edges until done is seen.
    task automatic wait_done8(input int inj, output int lat, output int bcnt, output int both);
        lat  = 0;
        bcnt = 0;
        both = 0;
        while (!done8 && lat < 40) begin
            if (busy8) bcnt++;
            if (inj >= 0) start8 = (lat == inj);
            @(posedge clk); #1;
            lat++;
            if (busy8 && done8) both++;
        end
        if (inj >= 0) start8 = 1'b0;
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b, input int inj);
        int lat, bcnt, both, exp_lat;
        logic [7:0] eq, er, hq, hr;
        exp_lat = (b == 0) ? 1 : 8;
        eq = (b == 0) ? 8'hFF : a / b;
        er = (b == 0) ? a : a % b;
        start8 = 1'b1;
        dvd8 = a;
        dvs8 = b;
        @(posedge clk); #1;
        start8 = 1'b0;
        dvd8 = 8'($urandom);
        dvs8 = 8'($urandom);
        if (inj >= 0) begin
            dvd8 = 8'd50;
            dvs8 = 8'd3;
        end
        wait_done8(inj, lat, bcnt, both);
        check("latency", lat, exp_lat);
        check("busy_cycles", bcnt, exp_lat);
        check("busy_and_done", both, 0);
        check("quotient", quo8, eq);
        check("remainder", rem8, er);
        check("div_by_zero", dbz8, (b == 0));
        hq = quo8;
        hr = rem8;
        @(posedge clk); #1;
        check("done_one_cycle", {busy8, done8}, 2'b00);
        check("quotient_hold", quo8, hq);
        check("remainder_hold", rem8, hr);
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int lat, bcnt, both, done_seen;
        logic [3:0] div3_q [16];
        logic [3:0] eq4, er4;
        logic [7:0] ra, rb;

        div3_q = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd2, 4'd2,
                   4'd2, 4'd3, 4'd3, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5};
        rst_b  = 1'b0;
        start8 = 1'b0;
        start4 = 1'b0;
        dvd8 = '0; dvs8 = '0; dvd4 = '0; dvs4 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state8", {busy8, done8, dbz8, quo8, rem8}, '0);
        check("reset_state4", {busy4, done4, dbz4, quo4, rem4}, '0);
        @(negedge clk);
        rst_b = 1'b1;

        // Directed cases
        op8(8'd200, 8'd3, -1);
        op8(8'd15, 8'd0, -1);
        op8(8'd9, 8'd4, -1);
        op8(8'd7, 8'd9, -1);
        op8(8'd255, 8'd1, -1);
        op8(8'd255, 8'd255, -1);
        op8(8'd254, 8'd128, -1);
        // Second start during BUSY with different operands must be ignored
        op8(8'd100, 8'd7, 2);

        // Start held high through DONE: 20/6 then 45/7 back to back
        start8 = 1'b1;
        dvd8 = 8'd20;
        dvs8 = 8'd6;
        @(posedge clk); #1;
        dvd8 = 8'd45;
        dvs8 = 8'd7;
        wait_done8(-1, lat, bcnt, both);
        check("b2b_first_latency", lat, 8);
        check("b2b_first_result", {quo8, rem8}, {8'd3, 8'd2});
        @(posedge clk); #1;
        check("b2b_no_idle", {busy8, done8}, 2'b10);
        start8 = 1'b0;
        wait_done8(-1, lat, bcnt, both);
        check("b2b_second_latency", lat, 8);
        check("b2b_second_result", {quo8, rem8}, {8'd6, 8'd3});
        @(posedge clk); #1;

        // Reset at iteration 4 of 200/3
        start8 = 1'b1;
        dvd8 = 8'd200;
        dvs8 = 8'd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_b = 1'b0;
        #1;
        check("abort_outputs", {busy8, done8, dbz8, quo8, rem8}, '0);
        done_seen = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done8) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        @(negedge clk);
        rst_b = 1'b1;
        op8(8'd50, 8'd5, -1);

        // Random operations
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            op8(ra, rb, -1);
        end

        // Exhaustive WIDTH=4 sweep
        for (int unsigned a = 0; a < 16; a++) begin
            for (int unsigned b = 0; b < 16; b++) begin
                eq4 = (b == 0) ? 4'hF : 4'(a / b);
                er4 = (b == 0) ? 4'(a) : 4'(a % b);
                start4 = 1'b1;
                dvd4 = 4'(a);
                dvs4 = 4'(b);
                @(posedge clk); #1;
                start4 = 1'b0;
                lat = 0;
                while (!done4 && lat < 20) begin
                    @(posedge clk); #1;
                    lat++;
                end
                check("w4_latency", lat, (b == 0) ? 1 : 4);
                check("w4_result", {dbz4, quo4, rem4}, {(b == 0), eq4, er4});
                if (b == 3) check("w4_div3_quotient", quo4, div3_q[a]);
                @(posedge clk); #1;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_div.md
SEQ_DIV -- requirements
Module: seq_div

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, the dividend, divisor, quotient and remainder width (legal range 2..32).
REQ-002 SHALL provide port clk  input  1  rising-edge clock, the single clock of the block.
REQ-003 SHALL provide port rst_b  input  1  asynchronous active-low reset.
REQ-004 SHALL provide port start  input  1  request pulse, sampled on the rising edge of clk.
REQ-005 SHALL provide port dividend  input  WIDTH  unsigned numerator, sampled when start is accepted.
REQ-006 SHALL provide port divisor  input  WIDTH  unsigned denominator, sampled when start is accepted.
REQ-007 SHALL provide port busy  output  1  high while a division is in progress.
REQ-008 SHALL provide port done  output  1  one-cycle pulse marking valid results.
REQ-009 SHALL provide port quotient  output  WIDTH  unsigned quotient.
REQ-010 SHALL provide port remainder  output  WIDTH  unsigned remainder.
REQ-011 SHALL provide port div_by_zero  output  1  error flag for the last completed operation.

Function
REQ-012 SHALL implement an FSM with three states: IDLE, BUSY and DONE.
REQ-013 SHALL accept start only in IDLE or DONE, latch dividend and divisor on that edge, clear the partial remainder and iteration counter, and move to BUSY.
REQ-014 SHALL ignore start while in BUSY, with no effect on state, operands or outputs.
REQ-015 SHALL use restoring division, one quotient bit per cycle, MSB first, shifting the next dividend bit into the partial remainder.
REQ-016 SHALL, on each iteration, subtract the divisor when the (WIDTH+1)-bit partial remainder is greater than or equal to it, writing quotient bit 1; otherwise it SHALL keep the remainder and write quotient bit 0.
REQ-017 SHALL hold the partial remainder in WIDTH+1 bits so that divisors with the MSB set never overflow.
REQ-018 SHALL complete after exactly WIDTH iterations, assert done in the cycle beginning WIDTH clock edges after the accepting edge, and enter DONE.
REQ-019 SHALL hold done high for exactly one cycle, then return to IDLE unless start is sampled high in DONE, in which case it SHALL go directly to BUSY.
REQ-020 SHALL update quotient, remainder and div_by_zero only on the edge that asserts done, and hold them stable until the next done.
REQ-021 SHALL assert busy from the cycle after the accepting edge through the last iteration cycle, and never together with done.
REQ-022 SHALL, when the latched divisor is 0, skip iteration, assert done one cycle after the accepting edge, and set quotient to all ones, remainder to the dividend and div_by_zero to 1.
REQ-023 SHALL clear div_by_zero on any non-zero-divisor completion.
REQ-024 SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every non-zero divisor.

Reset
REQ-025 SHALL, while rst_b is 0, immediately force state to IDLE, busy, done and div_by_zero to 0, quotient and remainder to 0, and clear the counter and internal registers.
REQ-026 SHALL abort any operation in progress when rst_b asserts, and SHALL NOT produce a done pulse for the aborted operation.
REQ-027 SHALL accept its first start on the first rising edge after rst_b deasserts.

Structure
REQ-028 SHALL take the FSM state encodings (IDLE=2'd0, BUSY=2'd1, DONE=2'd2) from a shared package/header; the iteration counter width SHALL be $clog2(WIDTH+1), derived locally.
REQ-029 SHALL put the compare-and-subtract step in one combinational sub-module, div_step, parametrised by WIDTH, with outputs next remainder and quotient bit.

Verification (WIDTH=8 unless stated)
REQ-030 SHALL show: 200/3 -> done exactly 8 cycles after start, quotient=66, remainder=2, div_by_zero=0, busy high 8 cycles.
REQ-031 SHALL show: 15/0 -> done 1 cycle after start, quotient=255, remainder=15, div_by_zero=1; a following 9/4 -> quotient=2, remainder=1, div_by_zero=0.
REQ-032 SHALL show boundary cases: 7/9 -> quotient=0, remainder=7; 255/1 -> quotient=255, remainder=0; 255/255 -> quotient=1, remainder=0; 254/128 -> quotient=1, remainder=126.
REQ-033 SHALL show: a second start 3 cycles into 100/7, with other operands -> ignored, result quotient=14, remainder=2; a start held high in DONE -> back-to-back operation with no IDLE cycle.
REQ-034 SHALL show: rst_b low mid-operation at iteration 4 -> outputs 0 immediately, no done pulse, and the next 50/5 -> quotient=10, remainder=0.
REQ-035 SHALL show, for WIDTH=4, an exhaustive sweep of all 256 dividend/divisor pairs checked against the golden division, with dividend 0..15 by divisor 3 giving quotient 0,0,0,1,1,1,2,2,2,3,3,3,4,4,4,5.
